fetch_stage: RTL and testbench

//   IF stage of the 5-stage RV32I pipeline: owns the PC, issues instruction reads to the
//   I-cache, and drives the IF/ID register whose if_ir is sliced into opcode/funct3/funct7 by the
//   ID-stage decoder. Absorbs ID stalls with a 1-entry skid buffer. Flushes on redirect from EX
//   (taken BR, JAL, JALR).

---
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage of the RV32I pipeline: owns the PC, issues single-outstanding I-cache reads,
// and feeds the IF/ID register through a one-entry skid buffer with EX-redirect flushing.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_read,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_rdata,
  input  logic        inst_resp,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_ir
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic {
    S_REQ     = 1'b0,
    S_DISCARD = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            inflight_q, inflight_d;
  logic            skid_full_q, skid_full_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_ir_q, skid_ir_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_ir_q, if_ir_d;
  logic [XLEN-1:0] redir_pc;

  assign redir_pc = redirect_pc & ~XLEN'(3);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_REQ;
    else     state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      pend_pc_q   <= '0;
      inflight_q  <= 1'b0;
      skid_full_q <= 1'b0;
      skid_pc_q   <= '0;
      skid_ir_q   <= '0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_ir_q     <= NOP;
    end else begin
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      inflight_q  <= inflight_d;
      skid_full_q <= skid_full_d;
      skid_pc_q   <= skid_pc_d;
      skid_ir_q   <= skid_ir_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_ir_q     <= if_ir_d;
    end
  end

  // Next-state: redirect first, then stale-read drain, then normal delivery
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    inflight_d  = inst_read & ~inst_resp;
    skid_full_d = skid_full_q;
    skid_pc_d   = skid_pc_q;
    skid_ir_d   = skid_ir_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_ir_d     = if_ir_q;

    if (redirect_valid) begin
      if_valid_d  = 1'b0;
      skid_full_d = 1'b0;
      if (state_q == S_DISCARD) begin
        if (inst_resp) begin
          pc_d    = redir_pc;
          state_d = S_REQ;
        end else begin
          pend_pc_d = redir_pc;
        end
      end else if (inflight_q && !inst_resp) begin
        pend_pc_d = redir_pc;
        state_d   = S_DISCARD;
      end else begin
        pc_d = redir_pc;
      end
    end else if (state_q == S_DISCARD) begin
      if (inst_resp) begin
        pc_d    = pend_pc_q;
        state_d = S_REQ;
      end
    end else begin
      if (!id_stall || !if_valid_q) if_valid_d = 1'b0;
      if (skid_full_q && !id_stall) begin
        if_valid_d  = 1'b1;
        if_pc_d     = skid_pc_q;
        if_ir_d     = skid_ir_q;
        skid_full_d = 1'b0;
      end
      if (inst_resp) begin
        pc_d = pc_q + XLEN'(4);
        if (if_valid_q && id_stall) begin
          skid_full_d = 1'b1;
          skid_pc_d   = pc_q;
          skid_ir_d   = inst_rdata;
        end else begin
          if_valid_d = 1'b1;
          if_pc_d    = pc_q;
          if_ir_d    = inst_rdata;
        end
      end
    end
  end

  // Outputs: a full skid suppresses new reads; a stale read keeps its request up
  always_comb begin
    inst_read = ~rst & ((state_q == S_DISCARD) | ~skid_full_q);
    inst_addr = pc_q;
    if_valid  = if_valid_q;
    if_pc     = if_pc_q;
    if_ir     = if_ir_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle-by-cycle vector table for reset, streaming, skid and
// redirect behaviour, plus hand-written sequences for double redirect, PC wrap and mid-read reset.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_resp;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_ir;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .inst_read      (inst_read),
    .inst_addr      (inst_addr),
    .inst_rdata     (inst_rdata),
    .inst_resp      (inst_resp),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_ir          (if_ir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        resp;
    logic [31:0] rdata;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_ir;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic r, logic rs, logic [31:0] rd, logic st, logic rv,
                              logic [31:0] rpc, logic er, logic [31:0] ea, logic ev,
                              logic [31:0] ep, logic [31:0] ei);
    vec_t v;
    v.rst = r; v.resp = rs; v.rdata = rd; v.stall = st; v.rv = rv; v.rpc = rpc;
    v.e_read = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_ir = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs a little after the edge, let combinational outputs settle.
  task automatic drive(input logic r, input logic rs, input logic [31:0] rd, input logic st,
                       input logic rv, input logic [31:0] rpc);
    rst = r; inst_resp = rs; inst_rdata = rd; id_stall = st;
    redirect_valid = rv; redirect_pc = rpc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic er, input logic [31:0] ea,
                         input logic ev, input logic [31:0] ep, input logic [31:0] ei);
    chk({tag, ".inst_read"}, 32'(inst_read), 32'(er));
    chk({tag, ".inst_addr"}, inst_addr, ea);
    chk({tag, ".if_valid"}, 32'(if_valid), 32'(ev));
    chk({tag, ".if_pc"}, if_pc, ep);
    chk({tag, ".if_ir"}, if_ir, ei);
  endtask

  initial begin
    //                 rst rsp rdata         stl rv  rpc            read addr          vld pc            ir
    vecs[0]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h60,         0, 32'h0,         NOP);
    vecs[1]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h60,         0, 32'h0,         NOP);
    vecs[2]  = mk(0, 1, 32'h00100093,  0, 0, 32'h0,         1, 32'h60,         0, 32'h0,         NOP);
    vecs[3]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h64,         1, 32'h60,        32'h00100093);
    vecs[4]  = mk(0, 1, 32'h00200113,  0, 0, 32'h0,         1, 32'h64,         0, 32'h60,        32'h00100093);
    vecs[5]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h68,         1, 32'h64,        32'h00200113);
    vecs[6]  = mk(0, 1, 32'h00300193,  0, 0, 32'h0,         1, 32'h68,         0, 32'h64,        32'h00200113);
    vecs[7]  = mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h6C,         1, 32'h68,        32'h00300193);
    vecs[8]  = mk(0, 1, 32'h00400213,  1, 0, 32'h0,         1, 32'h6C,         1, 32'h68,        32'h00300193);
    vecs[9]  = mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h70,         1, 32'h68,        32'h00300193);
    vecs[10] = mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h70,         1, 32'h68,        32'h00300193);
    vecs[11] = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h70,         1, 32'h68,        32'h00300193);
    vecs[12] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h70,         1, 32'h6C,        32'h00400213);
    vecs[13] = mk(0, 0, 32'h0,         0, 1, 32'h200,       1, 32'h70,         0, 32'h6C,        32'h00400213);
    vecs[14] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h70,         0, 32'h6C,        32'h00400213);
    vecs[15] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h70,         0, 32'h6C,        32'h00400213);
    vecs[16] = mk(0, 1, 32'hDEADBEEF,  0, 0, 32'h0,         1, 32'h70,         0, 32'h6C,        32'h00400213);
    vecs[17] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h200,        0, 32'h6C,        32'h00400213);
    vecs[18] = mk(0, 1, 32'h00500293,  0, 1, 32'h103,       1, 32'h200,        0, 32'h6C,        32'h00400213);
    vecs[19] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h100,        0, 32'h6C,        32'h00400213);
    vecs[20] = mk(0, 1, 32'h00600313,  0, 0, 32'h0,         1, 32'h100,        0, 32'h6C,        32'h00400213);
    vecs[21] = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h104,        1, 32'h100,       32'h00600313);

    drive(1, 0, 32'h0, 0, 0, 32'h0);
    tick();

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].resp, vecs[i].rdata, vecs[i].stall, vecs[i].rv, vecs[i].rpc);
      chk_all($sformatf("vec%0d", i), vecs[i].e_read, vecs[i].e_addr, vecs[i].e_valid,
              vecs[i].e_pc, vecs[i].e_ir);
      tick();
    end

    // Two redirects while a stale read drains: the later target wins.
    drive(0, 0, 32'h0, 0, 1, 32'h300);
    chk_all("dbl_redir0", 1, 32'h104, 0, 32'h100, 32'h00600313);
    tick();
    drive(0, 0, 32'h0, 0, 1, 32'h400);
    chk_all("dbl_redir1", 1, 32'h104, 0, 32'h100, 32'h00600313);
    tick();
    drive(0, 1, 32'hBAD0BAD0, 0, 0, 32'h0);
    chk_all("dbl_drain", 1, 32'h104, 0, 32'h100, 32'h00600313);
    tick();
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    chk_all("dbl_resume", 1, 32'h400, 0, 32'h100, 32'h00600313);
    tick();
    drive(0, 1, 32'h00700393, 0, 0, 32'h0);
    tick();

    // Redirect to the top word, then the sequential PC wraps to zero.
    drive(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC);
    chk_all("dbl_deliver", 1, 32'h404, 1, 32'h400, 32'h00700393);
    tick();
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    chk_all("wrap_req", 1, 32'hFFFF_FFFC, 0, 32'h400, 32'h00700393);
    tick();
    drive(0, 1, 32'h00800413, 0, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    chk_all("wrap_next", 1, 32'h0, 1, 32'hFFFF_FFFC, 32'h00800413);
    tick();

    // Reset with a read outstanding abandons it and restarts at the reset PC.
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    chk("rst_mid.inst_read", 32'(inst_read), 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    chk_all("rst_mid", 1, 32'h60, 0, 32'h0, NOP);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
